// File: rtl/rip_lsu.sv
// rip_lsu: load/store unit driving a word-addressed, byte-enabled, 1-cycle-latency data port.
// Optional RIP_LSU_MISALIGN_EN splits misaligned half/word accesses into two aligned word accesses.
module rip_lsu #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [NUM_COL-1:0]    mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WIDE_W = 2 * DATA_WIDTH;
    localparam int WIDE_C = 2 * NUM_COL;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
`ifdef RIP_LSU_MISALIGN_EN
        ST_ISSUE1 = 3'd2,
`endif
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic logic [NUM_COL-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = NUM_COL'(4'b0001);
            2'd1:    size_mask = NUM_COL'(4'b0011);
            2'd2:    size_mask = NUM_COL'(4'b1111);
            default: size_mask = {NUM_COL{1'b0}};
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd1:    misaligned = (off == 2'd3);
            2'd2:    misaligned = (off != 2'd0);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] raw,
                                                          input logic [1:0] size,
                                                          input logic uns);
        case (size)
            2'd0:    load_extend = {{(DATA_WIDTH-8){raw[7] & ~uns}}, raw[7:0]};
            2'd1:    load_extend = {{(DATA_WIDTH-16){raw[15] & ~uns}}, raw[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

    state_t                  state_r;
    logic                    store_r;
    logic [1:0]              size_r;
    logic                    uns_r;
    logic [1:0]              off_r;
`ifdef RIP_LSU_MISALIGN_EN
    logic                    span_r;
    logic [DATA_WIDTH-1:0]   lo_r;
    logic [NUM_COL-1:0]      we_hi_r;
    logic [DATA_WIDTH-1:0]   wdata_hi_r;
`endif

    logic [1:0]              off_s;
    logic [ADDR_WIDTH-1:0]   word_s;
    logic                    mis_s;
    logic                    illegal_s;
    logic [WIDE_W-1:0]       wide_data_s;
    logic [WIDE_C-1:0]       wide_be_s;
    logic [WIDE_W-1:0]       rd_pair_s;
    logic [WIDE_W-1:0]       rd_shift_s;
    logic                    unused_s;

    // Request decode: lane-positioned store data/enables and the load realignment path.
    always_comb begin
        off_s       = req_addr[1:0];
        word_s      = req_addr[ADDR_WIDTH+1:2];
        mis_s       = misaligned(req_size, off_s);
`ifdef RIP_LSU_MISALIGN_EN
        illegal_s   = (req_size == 2'd3);
        rd_pair_s   = span_r ? {mem_rdata, lo_r} : {{DATA_WIDTH{1'b0}}, mem_rdata};
`else
        illegal_s   = (req_size == 2'd3) || mis_s;
        rd_pair_s   = {{DATA_WIDTH{1'b0}}, mem_rdata};
`endif
        wide_data_s = {{DATA_WIDTH{1'b0}}, req_wdata} << {off_s, 3'b000};
        wide_be_s   = {{NUM_COL{1'b0}}, size_mask(req_size)} << off_s;
        rd_shift_s  = rd_pair_s >> {off_r, 3'b000};
    end

    // Upper address bits and upper halves of the wide paths are intentionally unused.
    assign unused_s = ^{req_addr[DATA_WIDTH-1:ADDR_WIDTH+2], wide_data_s[WIDE_W-1:DATA_WIDTH],
                        wide_be_s[WIDE_C-1:NUM_COL], rd_shift_s[WIDE_W-1:DATA_WIDTH]};

    // Request/memory/response sequencing with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
            mem_en     <= 1'b0;
            mem_addr   <= {ADDR_WIDTH{1'b0}};
            mem_we     <= {NUM_COL{1'b0}};
            mem_wdata  <= {DATA_WIDTH{1'b0}};
            store_r    <= 1'b0;
            size_r     <= 2'd0;
            uns_r      <= 1'b0;
            off_r      <= 2'd0;
`ifdef RIP_LSU_MISALIGN_EN
            span_r     <= 1'b0;
            lo_r       <= {DATA_WIDTH{1'b0}};
            we_hi_r    <= {NUM_COL{1'b0}};
            wdata_hi_r <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        store_r   <= req_store;
                        size_r    <= req_size;
                        uns_r     <= req_unsigned;
                        off_r     <= off_s;
                        if (illegal_s) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= {DATA_WIDTH{1'b0}};
                            state_r    <= ST_RESP;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_addr  <= word_s;
                            mem_we    <= req_store ? wide_be_s[NUM_COL-1:0] : {NUM_COL{1'b0}};
                            mem_wdata <= wide_data_s[DATA_WIDTH-1:0];
`ifdef RIP_LSU_MISALIGN_EN
                            span_r     <= mis_s;
                            we_hi_r    <= req_store ? wide_be_s[WIDE_C-1:NUM_COL] : {NUM_COL{1'b0}};
                            wdata_hi_r <= wide_data_s[WIDE_W-1:DATA_WIDTH];
`endif
                            state_r   <= ST_ISSUE0;
                        end
                    end
                end
                ST_ISSUE0: begin
`ifdef RIP_LSU_MISALIGN_EN
                    if (span_r) begin
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        mem_we    <= we_hi_r;
                        mem_wdata <= wdata_hi_r;
                        state_r   <= ST_ISSUE1;
                    end else begin
                        mem_en  <= 1'b0;
                        mem_we  <= {NUM_COL{1'b0}};
                        state_r <= ST_WAIT;
                    end
`else
                    mem_en  <= 1'b0;
                    mem_we  <= {NUM_COL{1'b0}};
                    state_r <= ST_WAIT;
`endif
                end
`ifdef RIP_LSU_MISALIGN_EN
                ST_ISSUE1: begin
                    lo_r    <= mem_rdata;
                    mem_en  <= 1'b0;
                    mem_we  <= {NUM_COL{1'b0}};
                    state_r <= ST_WAIT;
                end
`endif
                ST_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= store_r ? {DATA_WIDTH{1'b0}}
                                          : load_extend(rd_shift_s[DATA_WIDTH-1:0], size_r, uns_r);
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_en     <= 1'b0;
                    mem_we     <= {NUM_COL{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rip_lsu.sv
// tb_rip_lsu: directed plus random checks of rip_lsu against a byte-addressed reference memory.
module tb_rip_lsu;

`ifdef RIP_LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic [19:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    rip_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] wmem [int];   // memory the DUT talks to
    logic [7:0]  bmem [int];   // independent byte-level reference
    int n_cmp = 0;
    int n_mis = 0;

    logic [19:0] log_addr [4];
    logic [3:0]  log_we   [4];
    logic [31:0] log_wd   [4];
    int          log_cyc  [4];
    int          n_log;
    logic [31:0] last_rd;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] mem_read(input logic [19:0] a);
        int k = int'(a);
        return wmem.exists(k) ? wmem[k] : init_word(k);
    endfunction

    // Word memory with byte enables and one cycle of read latency.
    always @(posedge clk) begin
        logic [31:0] cur;
        if (mem_en) begin
            cur = mem_read(mem_addr);
            mem_rdata <= cur;
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) cur[8*i +: 8] = mem_wdata[8*i +: 8];
            wmem[int'(mem_addr)] = cur;
        end
    end

    function automatic logic [7:0] ref_byte(input int a);
        logic [31:0] w;
        if (bmem.exists(a)) return bmem[a];
        w = init_word(a / 4);
        return w[8*(a % 4) +: 8];
    endfunction

    function automatic int baddr(input logic [31:0] ad, input int i);
        return int'((ad + 32'(i)) & 32'h003FFFFF);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] ad, input logic [1:0] sz, input logic un);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = ref_byte(baddr(ad, i));
        if (sz == 2'd0 && !un) v = {{24{v[7]}}, v[7:0]};
        if (sz == 2'd1 && !un) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic poke(input int w, input logic [31:0] v);
        wmem[w] = v;
        for (int i = 0; i < 4; i++) bmem[w*4 + i] = v[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
        check("req_ready_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd, input int hold);
        logic mis, exp_err;
        logic [31:0] exp_rd;
        int exp_lat, exp_en, lat;
        mis     = (sz == 2'd1 && ad[1:0] == 2'd3) || (sz == 2'd2 && ad[1:0] != 2'd0);
        exp_err = (sz == 2'd3) || (mis && !MIS_EN);
        exp_rd  = (st || exp_err) ? 32'd0 : ref_load(ad, sz, un);
        exp_lat = exp_err ? 1 : (mis ? 4 : 3);
        exp_en  = exp_err ? 0 : (mis ? 2 : 1);
        resp_ready = (hold == 0);
        wait_ready();
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_log = 0; lat = 1;
        while (!resp_valid && lat < 20) begin
            if (mem_en) begin
                if (n_log < 4) begin
                    log_addr[n_log] = mem_addr; log_we[n_log] = mem_we;
                    log_wd[n_log] = mem_wdata; log_cyc[n_log] = lat;
                end
                if (!st) check("load_we_zero", 32'(mem_we), 32'd0);
                n_log++;
            end
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("resp_rdata", resp_rdata, exp_rd);
        check("mem_en_count", 32'(n_log), 32'(exp_en));
        last_rd = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("resp_done", 32'(resp_valid), 32'd0);
        if (st && !exp_err)
            for (int i = 0; i < (1 << sz); i++) bmem[baddr(ad, i)] = wd[8*i +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        // Aligned LW
        poke(32'h40, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0);
        check("lw_rdata", last_rd, 32'hDEADBEEF);
        check("lw_en_cycle", 32'(log_cyc[0]), 32'd1);
        check("lw_addr", 32'(log_addr[0]), 32'h40);
        check("lw_we", 32'(log_we[0]), 32'd0);

        // Byte/half sign and zero extension
        poke(32'h40, 32'h80FF1234);
        do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 0);
        check("lb_rdata", last_rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 0);
        check("lbu_rdata", last_rd, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 0);
        check("lh_rdata", last_rd, 32'hFFFF80FF);

        // SH at offset 1
        do_req(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000ABCD, 0);
        check("sh_we", 32'(log_we[0]), 32'h6);
        check("sh_wdata", log_wd[0], 32'h00ABCD00);
        check("sh_addr", 32'(log_addr[0]), 32'h40);
        check("sh_rdata", last_rd, 32'd0);

`ifdef RIP_LSU_MISALIGN_EN
        do_req(1'b1, 2'd2, 1'b0, 32'h103, 32'h11223344, 0);
        check("sw_split_we0", 32'(log_we[0]), 32'h8);
        check("sw_split_wd0", log_wd[0], 32'h44000000);
        check("sw_split_ad0", 32'(log_addr[0]), 32'h40);
        check("sw_split_we1", 32'(log_we[1]), 32'h7);
        check("sw_split_wd1", log_wd[1], 32'h00112233);
        check("sw_split_ad1", 32'(log_addr[1]), 32'h41);
        do_req(1'b0, 2'd2, 1'b0, 32'h103, 32'd0, 0);
        check("lw_split_rdata", last_rd, 32'h11223344);
        do_req(1'b0, 2'd2, 1'b0, 32'h003FFFFE, 32'd0, 0);
        check("wrap_ad1", 32'(log_addr[1]), 32'h0);
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'd0, 0);
        check("mis_err_rdata", last_rd, 32'd0);
`endif
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 0);
        do_req(1'b1, 2'd3, 1'b0, 32'h104, 32'hFFFFFFFF, 0);

        // Response back-pressure
        do_req(1'b0, 2'd2, 1'b0, 32'h108, 32'd0, 5);

        // Reset while ISSUE0 is active
        wait_ready();
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_mem_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_err", 32'(resp_err), 32'd0);
        check("mid_rst_resp_rdata", resp_rdata, 32'd0);
        check("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);

        // Random traffic in a low window and across the top-of-memory wrap
        for (int n = 0; n < 200; n++) begin
            logic [31:0] ad;
            logic [1:0]  sz;
            int r = $urandom_range(0, 9);
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            ad = ($urandom_range(0, 4) == 0) ? (32'h003FFFC0 + 32'($urandom_range(0, 63)))
                                             : 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
                   ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
